// File: rtl/game_pkg.sv
// Shared types and widths for the Breakout game sequencer.
package game_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SERVE = 3'd1,
    ST_PLAY  = 3'd2,
    ST_PAUSE = 3'd3,
    ST_OVER  = 3'd4,
    ST_WIN   = 3'd5
  } state_t;

  localparam int unsigned SCORE_W   = 9;
  localparam int unsigned SPEED_W   = 4;
  localparam int unsigned LIVES_W   = 3;
  localparam int unsigned SERVE_W   = 7;
  localparam int unsigned SCORE_MAX = 511;

endpackage

// File: rtl/hit_popcount.sv
// Combinational count of set bits in an N-bit block-hit vector.
module hit_popcount #(
  parameter int unsigned N = 22,
  parameter int unsigned W = $clog2(N + 1)
) (
  input  logic [N-1:0] i_vec,
  output logic [W-1:0] o_cnt
);

  // Ripple sum of the individual hit bits.
  always_comb begin
    o_cnt = '0;
    for (int unsigned i = 0; i < N; i++) begin
      o_cnt = o_cnt + W'(i_vec[i]);
    end
  end

endmodule

// File: rtl/game_ctrl.sv
// Breakout game sequencer: serve countdown, lives, score, ball speed,
// game over / win. Optional speed ramp enabled by GAME_CTRL_SPEED_RAMP_EN.
module game_ctrl
  import game_pkg::*;
#(
  parameter int unsigned LIVES           = 3,
  parameter int unsigned NUM_BLOCKS      = 22,
  parameter int unsigned SERVE_FRAMES    = 60,
  parameter int unsigned BASE_SPEED      = 5,
  parameter int unsigned MAX_SPEED       = 9,
  parameter int unsigned HITS_PER_STEP   = 4,
  parameter int unsigned SCORE_PER_BLOCK = 5
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_start,
  input  logic                  i_pause,
  input  logic                  i_ani_stb,
  input  logic                  i_ball_lost,
  input  logic [NUM_BLOCKS-1:0] i_col_detected,
  output logic                  o_mode,
  output logic                  o_animate,
  output logic [2:0]            o_state,
  output logic [LIVES_W-1:0]    o_lives,
  output logic [SPEED_W-1:0]    o_speed,
  output logic [SCORE_W-1:0]    o_score,
  output logic [SERVE_W-1:0]    o_serve_cnt,
  output logic                  o_game_over,
  output logic                  o_win
);

  localparam int unsigned POP_W = $clog2(NUM_BLOCKS + 1);

  state_t                  state_q, state_d;
  logic [LIVES_W-1:0]      lives_q, lives_d;
  logic [SPEED_W-1:0]      speed_q, speed_d;
  logic [SCORE_W-1:0]      score_q, score_d;
  logic [SERVE_W-1:0]      serve_q, serve_d;
  logic [NUM_BLOCKS-1:0]   prev_q, prev_d;
  logic [NUM_BLOCKS-1:0]   new_hits;
  logic [POP_W-1:0]        new_cnt;
  logic [15:0]             score_sum;
  logic [SCORE_W-1:0]      score_sat;
  logic [SPEED_W-1:0]      ramp_speed;
  logic                    lost_q;
  logic                    lost_ev;
  logic                    all_hit;
  logic                    mode_q, animate_q, over_q, win_q;

  assign new_hits = i_col_detected & ~prev_q;
  assign lost_ev  = i_ball_lost & ~lost_q;
  assign all_hit  = &i_col_detected;

  hit_popcount #(
    .N (NUM_BLOCKS),
    .W (POP_W)
  ) u_popcount (
    .i_vec (new_hits),
    .o_cnt (new_cnt)
  );

  // Score accumulation with saturation at the display maximum.
  always_comb begin
    score_sum = 16'(score_q) + 16'(SCORE_PER_BLOCK) * 16'(new_cnt);
    score_sat = (score_sum > 16'(SCORE_MAX)) ? SCORE_W'(SCORE_MAX) : score_sum[SCORE_W-1:0];
  end

`ifdef GAME_CTRL_SPEED_RAMP_EN
  localparam int unsigned HIT_W      = $clog2(HITS_PER_STEP + NUM_BLOCKS + 1);
  localparam int unsigned STEP_ITERS = (HITS_PER_STEP - 1 + NUM_BLOCKS) / HITS_PER_STEP;

  logic [HIT_W-1:0]   hit_q, hit_d, hit_acc;
  logic [SPEED_W-1:0] spd_acc;

  // Many blocks can fall in one frame, so the step is unrolled to cover
  // the worst case of every block being newly hit at once.
  always_comb begin
    hit_acc = hit_q + HIT_W'(new_cnt);
    spd_acc = speed_q;
    for (int unsigned i = 0; i < STEP_ITERS; i++) begin
      if (hit_acc >= HIT_W'(HITS_PER_STEP)) begin
        hit_acc = hit_acc - HIT_W'(HITS_PER_STEP);
        if (spd_acc < SPEED_W'(MAX_SPEED)) begin
          spd_acc = spd_acc + SPEED_W'(1);
        end
      end
    end
    ramp_speed = spd_acc;
  end
`else
  assign ramp_speed = SPEED_W'(BASE_SPEED);
`endif

  // Next-state and next-counter logic.
  always_comb begin
    state_d = state_q;
    lives_d = lives_q;
    speed_d = speed_q;
    score_d = score_q;
    serve_d = serve_q;
    prev_d  = prev_q;
`ifdef GAME_CTRL_SPEED_RAMP_EN
    hit_d   = hit_q;
`endif

    if (state_q == ST_SERVE || state_q == ST_PLAY || state_q == ST_PAUSE) begin
      prev_d  = i_col_detected;
      score_d = score_sat;
      speed_d = ramp_speed;
`ifdef GAME_CTRL_SPEED_RAMP_EN
      hit_d   = hit_acc;
`endif
    end

    unique case (state_q)
      ST_IDLE: begin
        lives_d = LIVES_W'(LIVES);
        speed_d = SPEED_W'(BASE_SPEED);
        score_d = '0;
        prev_d  = '0;
        serve_d = '0;
`ifdef GAME_CTRL_SPEED_RAMP_EN
        hit_d   = '0;
`endif
        if (i_start) begin
          state_d = ST_SERVE;
          serve_d = SERVE_W'(SERVE_FRAMES);
        end
      end
      ST_SERVE: begin
        if (all_hit) begin
          state_d = ST_WIN;
        end else if (i_ani_stb) begin
          if (serve_q == '0) state_d = ST_PLAY;
          else               serve_d = serve_q - SERVE_W'(1);
        end
      end
      ST_PLAY: begin
        // Win outranks a simultaneous lost ball, so lives stay intact.
        if (all_hit) begin
          state_d = ST_WIN;
        end else if (lost_ev) begin
          lives_d = lives_q - LIVES_W'(1);
          speed_d = SPEED_W'(BASE_SPEED);
          if (lives_q == LIVES_W'(1)) begin
            state_d = ST_OVER;
          end else begin
            state_d = ST_SERVE;
            serve_d = SERVE_W'(SERVE_FRAMES);
          end
        end else if (i_pause) begin
          state_d = ST_PAUSE;
        end
      end
      ST_PAUSE: begin
        if (all_hit)       state_d = ST_WIN;
        else if (!i_pause) state_d = ST_PLAY;
      end
      ST_OVER, ST_WIN: begin
        if (i_start) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, counters and decoded outputs.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= ST_IDLE;
      lives_q   <= LIVES_W'(LIVES);
      speed_q   <= SPEED_W'(BASE_SPEED);
      score_q   <= '0;
      serve_q   <= '0;
      prev_q    <= '0;
      lost_q    <= 1'b0;
      mode_q    <= 1'b0;
      animate_q <= 1'b0;
      over_q    <= 1'b0;
      win_q     <= 1'b0;
`ifdef GAME_CTRL_SPEED_RAMP_EN
      hit_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      lives_q   <= lives_d;
      speed_q   <= speed_d;
      score_q   <= score_d;
      serve_q   <= serve_d;
      prev_q    <= prev_d;
      lost_q    <= i_ball_lost;
      mode_q    <= (state_d != ST_IDLE);
      animate_q <= (state_d == ST_PLAY);
      over_q    <= (state_d == ST_OVER);
      win_q     <= (state_d == ST_WIN);
`ifdef GAME_CTRL_SPEED_RAMP_EN
      hit_q     <= hit_d;
`endif
    end
  end

  assign o_state     = state_q;
  assign o_lives     = lives_q;
  assign o_speed     = speed_q;
  assign o_score     = score_q;
  assign o_serve_cnt = serve_q;
  assign o_mode      = mode_q;
  assign o_animate   = animate_q;
  assign o_game_over = over_q;
  assign o_win       = win_q;

endmodule

// File: tb/tb_game_ctrl.sv
// Self-checking bench for game_ctrl: directed scenarios plus random play,
// all outputs compared every cycle against a behavioural game model.
module tb_game_ctrl;

  localparam int LIVES = 3;
  localparam int NB    = 22;
  localparam int SF    = 60;
  localparam int BASE  = 5;
  localparam int MAXS  = 9;
  localparam int HPS   = 4;
  localparam int SPB   = 5;

  localparam int S_IDLE = 0, S_SERVE = 1, S_PLAY = 2, S_PAUSE = 3, S_OVER = 4, S_WIN = 5;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0, pause = 1'b0, ani_stb = 1'b0, ball_lost = 1'b0;
  logic [NB-1:0] col = '0;
  logic          o_mode, o_animate, o_game_over, o_win;
  logic [2:0]    o_state, o_lives;
  logic [3:0]    o_speed;
  logic [8:0]    o_score;
  logic [6:0]    o_serve_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  // behavioural model
  int            m_state, m_lives, m_speed, m_score, m_serve, m_hits;
  logic [NB-1:0] m_prev;
  logic          m_lost_q;

  game_ctrl #(
    .LIVES           (LIVES),
    .NUM_BLOCKS      (NB),
    .SERVE_FRAMES    (SF),
    .BASE_SPEED      (BASE),
    .MAX_SPEED       (MAXS),
    .HITS_PER_STEP   (HPS),
    .SCORE_PER_BLOCK (SPB)
  ) dut (
    .i_clk          (clk),
    .i_rst_n        (rst_n),
    .i_start        (start),
    .i_pause        (pause),
    .i_ani_stb      (ani_stb),
    .i_ball_lost    (ball_lost),
    .i_col_detected (col),
    .o_mode         (o_mode),
    .o_animate      (o_animate),
    .o_state        (o_state),
    .o_lives        (o_lives),
    .o_speed        (o_speed),
    .o_score        (o_score),
    .o_serve_cnt    (o_serve_cnt),
    .o_game_over    (o_game_over),
    .o_win          (o_win)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_state  = S_IDLE;
    m_lives  = LIVES;
    m_speed  = BASE;
    m_score  = 0;
    m_serve  = 0;
    m_hits   = 0;
    m_prev   = '0;
    m_lost_q = 1'b0;
  endtask

  // One clock edge of the game rules, using the inputs currently applied.
  task automatic model_step();
    int   pop;
    int   tot;
    logic lost_ev;
    if (!rst_n) begin
      model_reset();
      return;
    end
    lost_ev  = ball_lost && !m_lost_q;
    m_lost_q = ball_lost;
    case (m_state)
      S_IDLE: begin
        m_lives = LIVES; m_speed = BASE; m_score = 0; m_prev = '0; m_hits = 0; m_serve = 0;
        if (start) begin
          m_state = S_SERVE;
          m_serve = SF;
        end
      end
      S_OVER, S_WIN: if (start) m_state = S_IDLE;
      default: begin
        pop     = $countones(col & ~m_prev);
        m_prev  = col;
        m_score = m_score + SPB * pop;
        if (m_score > 511) m_score = 511;
`ifdef GAME_CTRL_SPEED_RAMP_EN
        tot     = m_hits + pop;
        m_hits  = tot % HPS;
        m_speed = m_speed + tot / HPS;
        if (m_speed > MAXS) m_speed = MAXS;
`else
        tot     = pop;
        m_hits  = tot;
`endif
        if (&col) begin
          m_state = S_WIN;
        end else if (m_state == S_SERVE) begin
          if (ani_stb) begin
            if (m_serve == 0) m_state = S_PLAY;
            else              m_serve = m_serve - 1;
          end
        end else if (m_state == S_PLAY) begin
          if (lost_ev) begin
            m_lives = m_lives - 1;
            m_speed = BASE;
            if (m_lives == 0) m_state = S_OVER;
            else begin
              m_state = S_SERVE;
              m_serve = SF;
            end
          end else if (pause) begin
            m_state = S_PAUSE;
          end
        end else if (!pause) begin
          m_state = S_PLAY;
        end
      end
    endcase
  endtask

  task automatic check_all();
    chk("state",     o_state,     m_state);
    chk("mode",      o_mode,      (m_state != S_IDLE) ? 1 : 0);
    chk("animate",   o_animate,   (m_state == S_PLAY) ? 1 : 0);
    chk("lives",     o_lives,     m_lives);
    chk("speed",     o_speed,     m_speed);
    chk("score",     o_score,     m_score);
    chk("serve_cnt", o_serve_cnt, m_serve);
    chk("game_over", o_game_over, (m_state == S_OVER) ? 1 : 0);
    chk("win",       o_win,       (m_state == S_WIN) ? 1 : 0);
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check_all();
  endtask

  task automatic serve_to_play(output int n);
    n = 0;
    while (m_state != S_PLAY && n < 500) begin
      ani_stb = 1'b1;
      tick();
      n++;
    end
    ani_stb = 1'b0;
    if (m_state != S_PLAY) begin
      n_tests++;
      n_fail++;
      $display("FAIL serve_timeout: got state %0d expected %0d", m_state, S_PLAY);
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic pulse_lost();
    ball_lost = 1'b1;
    tick();
    ball_lost = 1'b0;
  endtask

  // Reset asserted between edges takes effect without waiting for a clock.
  task automatic async_reset();
    #2 rst_n = 1'b0;
    #1 model_reset();
    check_all();
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    int n;
    int lost_len;
    model_reset();
    tick();
    tick();
    rst_n = 1'b1;
    chk("rst_state", o_state, 0);
    chk("rst_lives", o_lives, 3);
    chk("rst_speed", o_speed, 5);
    chk("rst_mode",  o_mode,  0);
    tick();

    // serve countdown
    pulse_start();
    chk("t1_serve_state", o_state, 1);
    chk("t1_mode", o_mode, 1);
    chk("t1_animate", o_animate, 0);
    chk("t1_serve_cnt", o_serve_cnt, 60);
    serve_to_play(n);
    chk("t1_strobes", n, 61);
    chk("t1_play_animate", o_animate, 1);

    // scoring and speed step
    col = 22'h7;
    tick();
    chk("t3_score15", o_score, 15);
    col = 22'hF;
    tick();
    chk("t3_score20", o_score, 20);
`ifdef GAME_CTRL_SPEED_RAMP_EN
    chk("t3_speed", o_speed, 6);
`else
    chk("t3_speed", o_speed, 5);
`endif

    // lives down to game over
    pulse_lost();
    chk("t2_lives2", o_lives, 2);
    chk("t2_serve_state", o_state, 1);
    chk("t2_serve_reload", o_serve_cnt, 60);
    chk("t2_speed_base", o_speed, 5);
    serve_to_play(n);
    pulse_lost();
    serve_to_play(n);
    pulse_lost();
    chk("t2_over_state", o_state, 4);
    chk("t2_game_over", o_game_over, 1);
    chk("t2_lives0", o_lives, 0);
    pulse_start();
    chk("t2_idle", o_state, 0);
    col = '0;
    tick();

    // pause
    pulse_start();
    serve_to_play(n);
    pause = 1'b1;
    tick();
    chk("t5_pause_state", o_state, 3);
    chk("t5_pause_animate", o_animate, 0);
    repeat (5) tick();
    chk("t5_score_frozen", o_score, 0);
    chk("t5_lives_frozen", o_lives, 3);
    pause = 1'b0;
    tick();
    chk("t5_resume_state", o_state, 2);
    chk("t5_resume_animate", o_animate, 1);

    // reset mid-game
    col = 22'hFF;
    tick();
    chk("t6_score40", o_score, 40);
    #2 rst_n = 1'b0;
    #1 model_reset();
    chk("t6_state", o_state, 0);
    chk("t6_score", o_score, 0);
    chk("t6_lives", o_lives, 3);
    chk("t6_speed", o_speed, 5);
    chk("t6_mode",  o_mode,  0);
    col = '0;
    tick();
    rst_n = 1'b1;
    tick();

    // win beats simultaneous lost ball
    pulse_start();
    serve_to_play(n);
    col = 22'h3;
    tick();
    col = '1;
    ball_lost = 1'b1;
    tick();
    ball_lost = 1'b0;
    chk("t4_win_state", o_state, 5);
    chk("t4_win", o_win, 1);
    chk("t4_lives", o_lives, 3);
    chk("t4_score", o_score, 110);
    pulse_start();
    col = '0;
    tick();

    // random play
    lost_len = 0;
    for (int cyc = 0; cyc < 15000; cyc++) begin
      start   = ($urandom_range(0, 99) < 3);
      ani_stb = 1'($urandom_range(0, 1));
      if (lost_len > 0) begin
        ball_lost = 1'b1;
        lost_len--;
      end else begin
        ball_lost = 1'b0;
        if (m_state == S_PLAY && $urandom_range(0, 199) < 2) lost_len = $urandom_range(1, 3);
      end
      if ($urandom_range(0, 99) == 0) pause = ~pause;
      if (m_state == S_IDLE) col = '0;
      else if (m_state == S_PLAY && $urandom_range(0, 9) == 0) col[$urandom_range(0, NB - 1)] = 1'b1;
      if ($urandom_range(0, 2999) == 0) async_reset();
      else tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
